// File: rtl/pll_video_clkgen.sv
// All-digital pixel-clock generator: measures the clkin1 period in clk_tb cycles and
// synthesises clkout0 = f(clkin1)*MULT/DIV. Define PLL_CLKOUT_GATE_EN to hold clkout0 low until lock.
`timescale 1ns/1ps
module pll_video_clkgen #(
    parameter int CNT_W       = 12,
    parameter int MULT        = 3,
    parameter int DIV         = 2,
    parameter int TOL         = 1,
    parameter int LOCK_CYCLES = 16,
    parameter int ACC_W       = 16
) (
    input  logic             clk_tb,
    input  logic             rst_n,
    input  logic             clkin1,
    output logic             clkout0,
    output logic             pll_lock,
    output logic [CNT_W-1:0] ref_period
);

    localparam int                SC_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [ACC_W-1:0]  STEP    = ACC_W'(2 * MULT);
    localparam logic [CNT_W:0]    TOL_W   = (CNT_W + 1)'(TOL);
    localparam logic [SC_W-1:0]   LOCK_N  = SC_W'(LOCK_CYCLES);

    typedef enum logic [1:0] {UNARMED, MEASURE, TRACK, LOCKED} state_t;

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
        logic [CNT_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[CNT_W] ? (~d + (CNT_W + 1)'(1)) : d;
    endfunction

    logic             sync_p0, sync_p1, sync_p2;
    logic             rise;
    logic [CNT_W-1:0] cnt_q;
    logic             sat;
    state_t           state_q, state_d;
    logic [SC_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic             lock_q, lock_d;
    logic             in_tol;
    logic [ACC_W-1:0] acc_q, acc_d, limit, sum;
    logic             tog_q, tog_d, clk_d, clk_q;

    // Stage p0/p1: metastability synchronizer; p2: edge-detect register
    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= clkin1;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;
    assign sat  = (cnt_q == CNT_MAX) && !rise;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= rise ? CNT_W'(1) : cnt_sat_inc(cnt_q);
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNARMED;
            stable_q <= '0;
            ref_q    <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stable_q <= stable_d;
            ref_q    <= ref_d;
            lock_q   <= lock_d;
        end
    end

    // Saturated counter means the reference has gone away: drop everything and re-arm
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        ref_d    = ref_q;
        lock_d   = lock_q;
        in_tol   = (abs_diff(cnt_q, ref_q) <= TOL_W);
        if (sat) begin
            state_d  = UNARMED;
            stable_d = '0;
            ref_d    = '0;
            lock_d   = 1'b0;
        end else begin
            case (state_q)
                UNARMED: if (rise) state_d = MEASURE;
                MEASURE: if (rise) begin
                    ref_d    = cnt_q;
                    stable_d = '0;
                    state_d  = TRACK;
                end
                TRACK: begin
                    if (rise) begin
                        ref_d    = cnt_q;
                        stable_d = in_tol ? stable_q + SC_W'(1) : '0;
                    end else if (stable_q == LOCK_N) begin
                        state_d = LOCKED;
                        lock_d  = 1'b1;
                    end
                end
                LOCKED: if (rise) begin
                    ref_d = cnt_q;
                    if (!in_tol) begin
                        state_d  = TRACK;
                        stable_d = '0;
                        lock_d   = 1'b0;
                    end
                end
                default: state_d = UNARMED;
            endcase
        end
    end

    // Phase accumulator wraps at DIV*ref_period; each wrap is one half-period of clkout0
    always_comb begin
        limit = ACC_W'(DIV) * ACC_W'(ref_q);
        sum   = acc_q + STEP;
        acc_d = sum;
        tog_d = tog_q;
        if (sat || ref_q == '0) begin
            acc_d = '0;
            tog_d = 1'b0;
        end else if (STEP >= limit) begin
            acc_d = '0;
            tog_d = ~tog_q;
        end else if (sum >= limit) begin
            acc_d = sum - limit;
            tog_d = ~tog_q;
        end
`ifdef PLL_CLKOUT_GATE_EN
        clk_d = tog_d & lock_d;
`else
        clk_d = tog_d;
`endif
    end

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            tog_q <= 1'b0;
            clk_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            tog_q <= tog_d;
            clk_q <= clk_d;
        end
    end

    assign clkout0    = clk_q;
    assign pll_lock   = lock_q;
    assign ref_period = ref_q;

endmodule

// File: tb/tb_pll_video_clkgen.sv
// Scoreboard bench for pll_video_clkgen: clkin1 is driven synchronously to clk_tb so every
// measured period is exact; a period-level model predicts ref_period and pll_lock per edge.
`timescale 1ns/1ps
module tb_pll_video_clkgen;

    logic        clk_tb = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clkin1 = 1'b0;
    logic        clkout0;
    logic        pll_lock;
    logic [11:0] ref_period;

    pll_video_clkgen dut (
        .clk_tb     (clk_tb),
        .rst_n      (rst_n),
        .clkin1     (clkin1),
        .clkout0    (clkout0),
        .pll_lock   (pll_lock),
        .ref_period (ref_period)
    );

    always #1 clk_tb = ~clk_tb;

    typedef struct {
        int ref_p;
        int lock;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_state  = 0;
    int m_ref    = 0;
    int m_stable = 0;
    int m_lock   = 0;
    int prev_len = 10;

    int   tog_total  = 0;
    int   lock_rises = 0;
    logic prev_clk   = 1'b0;
    logic prev_lock  = 1'b0;

    always @(negedge clk_tb) begin
        if (clkout0 !== prev_clk) tog_total <= tog_total + 1;
        if (pll_lock === 1'b1 && prev_lock === 1'b0) lock_rises <= lock_rises + 1;
        prev_clk  <= clkout0;
        prev_lock <= pll_lock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic model_rise(input int m);
        case (m_state)
            0: m_state = 1;
            1: begin m_ref = m; m_stable = 0; m_state = 2; end
            2: begin
                m_stable = (absd(m, m_ref) <= 1) ? m_stable + 1 : 0;
                m_ref    = m;
                if (m_stable == 16) begin m_state = 3; m_lock = 1; end
            end
            default: begin
                if (absd(m, m_ref) > 1) begin m_state = 2; m_stable = 0; m_lock = 0; end
                m_ref = m;
            end
        endcase
    endtask

    task automatic model_reset();
        m_state = 0; m_ref = 0; m_stable = 0; m_lock = 0;
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #0.5;
    endtask

    // One clkin1 period of 2*half clk_tb cycles; the DUT result for this edge settles within 5 cycles
    task automatic ref_cycle(input int half);
        exp_t e;
        model_rise(prev_len);
        prev_len = 2 * half;
        sb.push_back('{m_ref, m_lock});
        clkin1 = 1'b1;
        for (int i = 0; i < half; i++) begin
            tick();
            if (i == 4) begin
                e = sb.pop_front();
                chk("ref_period", 32'(ref_period), 32'(e.ref_p));
                chk("pll_lock", 32'(pll_lock), 32'(e.lock));
            end
        end
        clkin1 = 1'b0;
        repeat (half) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lr0, n;
        // Reset held for 20 ns while clkin1 runs
        clkin1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) clkin1 = 1'b0;
            tick();
            if (i % 3 == 0) begin
                chk("rst_clkout0", 32'(clkout0), 32'd0);
                chk("rst_lock", 32'(pll_lock), 32'd0);
                chk("rst_ref", 32'(ref_period), 32'd0);
            end
        end
        rst_n = 1'b1;
        model_reset();
        t0  = tog_total;
        lr0 = lock_rises;

        repeat (17) ref_cycle(5);
        n = tog_total - t0;
`ifdef PLL_CLKOUT_GATE_EN
        chk("prelock_toggles", 32'(n), 32'd0);
`else
        chk("prelock_toggles_seen", 32'(n > 0), 32'd1);
`endif
        repeat (13) ref_cycle(5);
        chk("lock_rise_count", 32'(lock_rises - lr0), 32'd1);

        t0 = tog_total;
        repeat (20) ref_cycle(5);
        chk("toggles_50mhz", 32'(tog_total - t0), 32'd60);
        chk("lock_rise_count_2", 32'(lock_rises - lr0), 32'd1);

        // Reference loss: clkin1 stops low
        clkin1 = 1'b0;
        repeat (3000) tick();
        chk("loss_hold_lock", 32'(pll_lock), 32'd1);
        chk("loss_hold_ref", 32'(ref_period), 32'd10);
        repeat (1200) tick();
        chk("loss_lock", 32'(pll_lock), 32'd0);
        chk("loss_ref", 32'(ref_period), 32'd0);
        chk("loss_clkout0", 32'(clkout0), 32'd0);
        model_reset();
        lr0 = lock_rises;
        repeat (20) ref_cycle(5);
        chk("relock_rise_count", 32'(lock_rises - lr0), 32'd1);

        // Frequency step to 25 MHz
        repeat (20) ref_cycle(10);
        chk("step_relock", 32'(pll_lock), 32'd1);
        t0 = tog_total;
        repeat (10) ref_cycle(10);
        chk("toggles_25mhz", 32'(tog_total - t0), 32'd30);

        // Asynchronous reset mid-operation
        clkin1 = 1'b1;
        repeat (3) tick();
        rst_n = 1'b0;
        #0.25;
        chk("midrst_clkout0", 32'(clkout0), 32'd0);
        chk("midrst_lock", 32'(pll_lock), 32'd0);
        chk("midrst_ref", 32'(ref_period), 32'd0);
        repeat (4) tick();
        chk("midrst_hold_ref", 32'(ref_period), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
